// File: rtl/gmii2fifo_pack_pkg.sv
// Shared definitions for the GMII RX packer and its TX counterpart: lane layout, SFD, FSM states.
package gmii2fifo_pack_pkg;

  localparam int         LANE_W = 9;
  localparam logic [7:0] SFD    = 8'hD5;

  typedef struct packed {
    logic       dv;
    logic [7:0] dat;
  } lane_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_DATA = 3'd2,
    ST_GAP  = 3'd3,
    ST_DROP = 3'd4
  } state_t;

  function automatic int idx_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/gmii2fifo_pack_byte_packer.sv
// Lane accumulator: places pushed bytes into successive lanes and presents the full or flushed word
// combinationally in the cycle the last lane arrives or the frame ends.
module gmii2fifo_pack_byte_packer
  import gmii2fifo_pack_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic [7:0]              byte_i,
  input  logic                    flush_i,
  output logic                    word_rdy_o,
  output logic [LANES*LANE_W-1:0] word_o
);

  localparam int IW = idx_w(LANES);

  lane_t [LANES-1:0] acc_q, acc_d, word;
  logic  [IW-1:0]    idx_q, idx_d;
  logic              last;

  assign last = (idx_q == IW'(LANES - 1));

  always_comb begin
    word = acc_q;
    if (push_i) word[idx_q] = {1'b1, byte_i};
  end

  assign word_o     = word;
  assign word_rdy_o = (push_i && last) || (flush_i && !push_i && (idx_q != '0));

  // Lanes above idx stay zero because the accumulator is cleared on every word emission.
  always_comb begin
    acc_d = acc_q;
    idx_d = idx_q;
    if (push_i) begin
      if (last) begin
        acc_d = '0;
        idx_d = '0;
      end else begin
        acc_d = word;
        idx_d = idx_q + 1'b1;
      end
    end else if (flush_i) begin
      acc_d = '0;
      idx_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      idx_q <= '0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/gmii2fifo_pack.sv
// GMII RX to FIFO writer packing LANES {dv,byte} lanes per word, with inter-frame gap words and
// drop-on-full. GMII2FIFO_STRIP_PREAMBLE_EN removes preamble/SFD before packing.
module gmii2fifo_pack
  import gmii2fifo_pack_pkg::*;
#(
  parameter int LANES = 4,
  parameter int GAP   = 2,
  parameter int CNT_W = 16
) (
  input  logic                    gmii_rx_clk,
  input  logic                    sys_rst_n,
  input  logic                    gmii_rx_dv,
  input  logic [7:0]              gmii_rxd,
  input  logic                    full,
  output logic [LANES*LANE_W-1:0] din,
  output logic                    wr_en,
  output logic                    wr_clk,
  output logic [CNT_W-1:0]        frame_cnt,
  output logic [CNT_W-1:0]        drop_cnt
);

  localparam int GW = $clog2(GAP + 1);

  logic                    dv_q, dv_p_q;
  logic [7:0]              rxd_q, rxd_p_q;
  state_t                  state_q, state_d;
  logic [GW-1:0]           gap_q, gap_d;
  logic [LANES*LANE_W-1:0] din_q, din_d, word;
  logic                    wr_en_q, wr_en_d;
  logic [CNT_W-1:0]        frame_q, frame_d, drop_q, drop_d;
  logic                    push, flush, word_rdy, wr_fail, gap_try, gap_wr;

  assign wr_clk = gmii_rx_clk;

  // Second input stage puts the write two edges after capture, matching the 9-bit writer timing.
  always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dv_q    <= 1'b0;
      rxd_q   <= '0;
      dv_p_q  <= 1'b0;
      rxd_p_q <= '0;
    end else begin
      dv_q    <= gmii_rx_dv;
      rxd_q   <= gmii_rxd;
      dv_p_q  <= dv_q;
      rxd_p_q <= rxd_q;
    end
  end

`ifdef GMII2FIFO_STRIP_PREAMBLE_EN
  assign push = dv_p_q && ((state_q == ST_DATA) || ((state_q == ST_GAP) && (gap_q != '0)));
`else
  assign push = dv_p_q && ((state_q == ST_DATA) || (state_q == ST_IDLE) ||
                           ((state_q == ST_GAP) && (gap_q != '0)));
`endif
  assign flush = !dv_p_q && (state_q == ST_DATA);

  gmii2fifo_pack_byte_packer #(.LANES(LANES)) u_packer (
    .clk        (gmii_rx_clk),
    .rst_n      (sys_rst_n),
    .push_i     (push),
    .byte_i     (rxd_p_q),
    .flush_i    (flush),
    .word_rdy_o (word_rdy),
    .word_o     (word)
  );

  assign wr_fail = word_rdy && full;
  // A frame ending on a word boundary leaves the write slot free, so the first gap word goes out at once.
  assign gap_try = !dv_p_q && ((state_q == ST_GAP) || ((state_q == ST_DATA) && !word_rdy));
  assign gap_wr  = gap_try && !full;

  always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      din_q   <= '0;
      wr_en_q <= 1'b0;
      frame_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      din_q   <= din_d;
      wr_en_q <= wr_en_d;
      frame_q <= frame_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
`ifdef GMII2FIFO_STRIP_PREAMBLE_EN
        if (dv_p_q) state_d = (rxd_p_q == SFD) ? ST_DATA : ST_PRE;
`else
        if (dv_p_q) state_d = ST_DATA;
`endif
      end
`ifdef GMII2FIFO_STRIP_PREAMBLE_EN
      ST_PRE: begin
        if (!dv_p_q)               state_d = ST_IDLE;
        else if (rxd_p_q == SFD)   state_d = ST_DATA;
      end
`endif
      ST_DATA: begin
        if (!dv_p_q) begin
          state_d = ST_GAP;
          gap_d   = gap_wr ? GW'(1) : '0;
          if (gap_wr && (GAP == 1)) state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (!dv_p_q) begin
          state_d = ST_GAP;
          gap_d   = '0;
        end
      end
      ST_GAP: begin
        if (dv_p_q) begin
          state_d = (gap_q != '0) ? ST_DATA : ST_DROP;
        end else if (gap_wr) begin
          gap_d = gap_q + 1'b1;
          if (gap_q == GW'(GAP - 1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A failed write after the frame already ended skips DROP, which would only wait for dv=0.
    if (wr_fail) begin
      state_d = dv_p_q ? ST_DROP : ST_GAP;
      gap_d   = '0;
    end
  end

  always_comb begin
    wr_en_d = 1'b0;
    din_d   = din_q;
    frame_d = frame_q;
    drop_d  = drop_q;
    if (word_rdy && !full) begin
      wr_en_d = 1'b1;
      din_d   = word;
    end else if (gap_wr) begin
      wr_en_d = 1'b1;
      din_d   = '0;
    end
    if ((state_q == ST_DATA) && !dv_p_q && !wr_fail && (frame_q != '1))
      frame_d = frame_q + 1'b1;
    if ((wr_fail || ((state_q == ST_GAP) && dv_p_q && (gap_q == '0))) && (drop_q != '1))
      drop_d = drop_q + 1'b1;
  end

  assign din       = din_q;
  assign wr_en     = wr_en_q;
  assign frame_cnt = frame_q;
  assign drop_cnt  = drop_q;

endmodule
